// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
// Shares one single-port BRAM controller port among NREQ requesters.
// Arbitration is round-robin (MODE=0) or fixed priority with index 0
// highest (MODE=1). Each grant becomes a registered memory command one
// cycle later. Read commands carry a requester tag down a RD_LAT-deep
// pipe, so the returning data is steered to the requester that asked.
//
// Ports
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   req_valid/we       : per-requester request strobe and direction
//   req_addr/wdata     : packed per-requester address and write data
//   req_ack            : one-hot, combinational, request accepted this cycle
//   rsp_valid/rsp_data : one-hot registered read response and shared data
//   mem_ready          : controller can take a command this cycle
//   mem_en/we/addr/wdata : registered command to the BRAM controller
//   mem_rdata          : read data, valid RD_LAT cycles after a read mem_en
module mem_arbiter_rr #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2,
    parameter int MODE   = 0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    input  logic                   mem_ready,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    int                scan_idx;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [PTR_W-1:0]  mem_tag_q, mem_tag_d;

    // Tag pipe: stage RD_LAT-1 lines up with mem_rdata for the read it tracks.
    logic              pipe_vld_q [RD_LAT];
    logic              pipe_vld_d [RD_LAT];
    logic [PTR_W-1:0]  pipe_tag_q [RD_LAT];
    logic [PTR_W-1:0]  pipe_tag_d [RD_LAT];

    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Grant selection. Round-robin scans ptr, ptr+1, ... with wrap; fixed
    // priority scans from index 0. The first eligible index found wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        if (!wb_rst_i && mem_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                if (MODE == 1) begin
                    scan_idx = k;
                end else begin
                    scan_idx = (int'(ptr_q) + k) % NREQ;
                end
                if (!grant_any && req_valid[PTR_W'(scan_idx)]) begin
                    grant_any = 1'b1;
                    grant_idx = PTR_W'(scan_idx);
                end
            end
        end
    end

    always_comb begin
        req_ack = '0;
        if (grant_any) begin
            req_ack[grant_idx] = 1'b1;
        end
    end

    // Next-state for pointer and the registered command. Without a grant the
    // command fields hold and only the strobe drops.
    always_comb begin
        ptr_d       = ptr_q;
        mem_en_d    = grant_any;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_tag_d   = mem_tag_q;
        if (grant_any) begin
            ptr_d       = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PTR_W'(1);
            mem_we_d    = req_we[grant_idx];
            mem_addr_d  = req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
            mem_wdata_d = req_wdata[int'(grant_idx) * DATA_W +: DATA_W];
            mem_tag_d   = grant_idx;
        end
    end

    // A read enters the tag pipe while its command is on the memory port;
    // writes enter as empty slots so they never raise a response.
    always_comb begin
        pipe_vld_d[0] = mem_en_q & ~mem_we_q;
        pipe_tag_d[0] = mem_tag_q;
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_tag_d[s] = pipe_tag_q[s-1];
        end

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (pipe_vld_q[RD_LAT-1]) begin
            rsp_valid_d[pipe_tag_q[RD_LAT-1]] = 1'b1;
            rsp_data_d                        = mem_rdata;
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_tag_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            // NOTE: the tag pipe is cleared on reset so reads in flight at reset never produce a response.
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_vld_q[s] <= 1'b0;
                pipe_tag_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_tag_q   <= mem_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_tag_q  <= pipe_tag_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: instance a is round-robin with RD_LAT=2,
// instance b is fixed priority with RD_LAT=3. Both share request payload,
// mem_ready and reset; each has its own req_valid and its own BRAM model.
module tb_mem_arbiter_rr;

    localparam int NREQ = 4;
    localparam int AW   = 13;
    localparam int DW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NREQ-1:0]  rv_a, rv_b, we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic             mem_ready;

    logic [NREQ-1:0] ack_a, ack_b, rspv_a, rspv_b;
    logic [DW-1:0]   rspd_a, rspd_b, mwdata_a, mwdata_b, mrdata_a, mrdata_b;
    logic            men_a, men_b, mwe_a, mwe_b;
    logic [AW-1:0]   maddr_a, maddr_b;

    mem_arbiter_rr #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MODE(0)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(rv_a), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_ack(ack_a),
        .rsp_valid(rspv_a), .rsp_data(rspd_a), .mem_ready(mem_ready),
        .mem_en(men_a), .mem_we(mwe_a), .mem_addr(maddr_a),
        .mem_wdata(mwdata_a), .mem_rdata(mrdata_a)
    );

    mem_arbiter_rr #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MODE(1)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(rv_b), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_ack(ack_b),
        .rsp_valid(rspv_b), .rsp_data(rspd_b), .mem_ready(mem_ready),
        .mem_en(men_b), .mem_we(mwe_b), .mem_addr(maddr_b),
        .mem_wdata(mwdata_b), .mem_rdata(mrdata_b)
    );

    // ---------------- BRAM models ----------------
    function automatic logic [31:0] preload(input logic [7:0] a);
        case (a)
            8'h01:   return 32'h1111_1111;
            8'h02:   return 32'h2222_2222;
            8'h05:   return 32'hDEAD_BEEF;
            8'h07:   return 32'h7777_7777;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] mem_a [256];
    bit          wr_a  [256];
    logic [31:0] rdp_a [2];
    logic [31:0] mem_b [256];
    bit          wr_b  [256];
    logic [31:0] rdp_b [3];

    always @(posedge clk) begin
        if (men_a && mwe_a) begin
            mem_a[maddr_a[7:0]] <= mwdata_a;
            wr_a[maddr_a[7:0]]  <= 1'b1;
        end
        rdp_a[0] <= (men_a && !mwe_a) ?
                    (wr_a[maddr_a[7:0]] ? mem_a[maddr_a[7:0]] : preload(maddr_a[7:0])) : 32'h0;
        rdp_a[1] <= rdp_a[0];
    end
    assign mrdata_a = rdp_a[1];

    always @(posedge clk) begin
        if (men_b && mwe_b) begin
            mem_b[maddr_b[7:0]] <= mwdata_b;
            wr_b[maddr_b[7:0]]  <= 1'b1;
        end
        rdp_b[0] <= (men_b && !mwe_b) ?
                    (wr_b[maddr_b[7:0]] ? mem_b[maddr_b[7:0]] : preload(maddr_b[7:0])) : 32'h0;
        rdp_b[1] <= rdp_b[0];
        rdp_b[2] <= rdp_b[1];
    end
    assign mrdata_b = rdp_b[2];

    // ---------------- scoreboard ----------------
    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;

    exp_t q_ack[$];
    exp_t q_cmd[$];
    exp_t q_rsp[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_on = 1'b0;
    bit final_chk = 1'b0;
    bit done = 1'b0;

    task automatic compare(input string name, input int inst, input bit obs,
                           input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                           input bit ex, input exp_t e, input bit use_v2);
        bit ok;
        n_cmp++;
        ok = obs && ex && (o0 === e.v0) && (o1 === e.v1) && (!use_v2 || (o2 === e.v2));
        if (!ok) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d: got present=%0b %h %h %h, expected present=%0b %h %h %h",
                     name, inst, cyc, obs, o0, o1, o2, ex, e.v0, e.v1, e.v2);
        end
    endtask

    // Pops an expectation whenever a DUT output appears or an expectation
    // falls due; either without the other is a mismatch.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] o0, o1, o2;
        bit          obs, ex;
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                // req_ack
                e  = '{inst: 0, cyc: 0, v0: 0, v1: 0, v2: 0};
                o0 = (i == 0) ? 32'(ack_a) : 32'(ack_b);
                obs = (o0 !== 32'h0);
                ex  = (q_ack.size() > 0) && (q_ack[0].inst == i) && (q_ack[0].cyc == cyc);
                if (ex) e = q_ack.pop_front();
                if (obs || ex) compare("req_ack", i, obs, o0, 32'h0, 32'h0, ex, e, 1'b0);

                // memory command
                e  = '{inst: 0, cyc: 0, v0: 0, v1: 0, v2: 0};
                obs = ((i == 0) ? men_a : men_b) === 1'b1;
                o0 = (i == 0) ? 32'(mwe_a) : 32'(mwe_b);
                o1 = (i == 0) ? 32'(maddr_a) : 32'(maddr_b);
                o2 = (i == 0) ? mwdata_a : mwdata_b;
                ex  = (q_cmd.size() > 0) && (q_cmd[0].inst == i) && (q_cmd[0].cyc == cyc);
                if (ex) e = q_cmd.pop_front();
                if (obs || ex) compare("mem_cmd", i, obs, o0, o1, o2, ex, e, e.v0[0]);

                // read response
                e  = '{inst: 0, cyc: 0, v0: 0, v1: 0, v2: 0};
                o0 = (i == 0) ? 32'(rspv_a) : 32'(rspv_b);
                o1 = (i == 0) ? rspd_a : rspd_b;
                obs = (o0 !== 32'h0);
                ex  = (q_rsp.size() > 0) && (q_rsp[0].inst == i) && (q_rsp[0].cyc == cyc);
                if (ex) e = q_rsp.pop_front();
                if (obs || ex) compare("rsp", i, obs, o0, o1, 32'h0, ex, e, 1'b0);
            end
            if (final_chk && !done) begin
                n_cmp++;
                if (q_ack.size() + q_cmd.size() + q_rsp.size() != 0) begin
                    n_err++;
                    $display("FAIL leftover: %0d expected events never seen, required 0",
                             q_ack.size() + q_cmd.size() + q_rsp.size());
                end
                done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [AW-1:0] a_addr [4] = '{13'h001, 13'h002, 13'h005, 13'h007};
    logic [31:0]   a_data [4] = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h7777_7777};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit w, input logic [AW-1:0] ad, input logic [31:0] wd);
        we[i]               = w;
        addr[i*AW +: AW]    = ad;
        wdata[i*DW +: DW]   = wd;
    endtask

    // Expected ack now, command next cycle, and for a kept read the
    // response RD_LAT+2 cycles after the grant.
    task automatic expect_grant(input int inst, input int g, input bit w, input logic [AW-1:0] ad,
                                input logic [31:0] wd, input logic [31:0] rd, input bit rsp_ok);
        exp_t e;
        e.inst = inst; e.cyc = cyc; e.v0 = 32'(1) << g; e.v1 = 32'h0; e.v2 = 32'h0;
        q_ack.push_back(e);
        e.cyc = cyc + 1; e.v0 = 32'(w); e.v1 = 32'(ad); e.v2 = wd;
        q_cmd.push_back(e);
        if (!w && rsp_ok) begin
            e.cyc = cyc + ((inst == 0) ? 2 : 3) + 2; e.v0 = 32'(1) << g; e.v1 = rd; e.v2 = 32'h0;
            q_rsp.push_back(e);
        end
    endtask

    initial begin
        rst = 1'b1; rv_a = '1; rv_b = '0; we = '0; addr = '0; wdata = '0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, a_addr[i], 32'h0);

        // Reset held three cycles with every requester valid: nothing may appear.
        step(); mon_on = 1'b1;
        step();
        step();

        // Release: req 0 first, then round-robin rotation over 12 cycles.
        for (int k = 0; k < 12; k++) begin
            step(); rst = 1'b0;
            expect_grant(0, k % 4, 1'b0, a_addr[k % 4], 32'h0, a_data[k % 4], 1'b1);
        end
        step(); rv_a = '0;
        repeat (8) step();

        // Single read, req 2 at 0x005.
        rv_a = 4'b0100;
        expect_grant(0, 2, 1'b0, 13'h005, 32'h0, 32'hDEAD_BEEF, 1'b1);
        step(); rv_a = '0;
        repeat (8) step();

        // Back-pressure: five cycles of mem_ready low, then grant at once.
        mem_ready = 1'b0; rv_a = 4'b0010;
        repeat (5) step();
        mem_ready = 1'b1;
        expect_grant(0, 1, 1'b0, 13'h002, 32'h0, 32'h2222_2222, 1'b1);
        step(); rv_a = '0;
        repeat (8) step();

        // Reset one cycle after a read grant: command still shows, response never.
        rv_a = 4'b0001;
        expect_grant(0, 0, 1'b0, 13'h001, 32'h0, 32'h0, 1'b0);
        step(); rv_a = '0; rst = 1'b1;
        step();
        // Pointer back at 0: with 0 and 3 pending, 0 wins first, then 3.
        step(); rst = 1'b0; rv_a = 4'b1001;
        expect_grant(0, 0, 1'b0, 13'h001, 32'h0, 32'h1111_1111, 1'b1);
        step(); rv_a = 4'b1000;
        expect_grant(0, 3, 1'b0, 13'h007, 32'h0, 32'h7777_7777, 1'b1);
        step(); rv_a = '0;
        repeat (8) step();

        // Fixed priority: 0 and 3 both writing; 3 starves until 0 drops.
        set_req(0, 1'b1, 13'h020, 32'hAAAA_0000);
        set_req(3, 1'b1, 13'h030, 32'hBBBB_0003);
        rv_b = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            expect_grant(1, 0, 1'b1, 13'h020, 32'hAAAA_0000, 32'h0, 1'b0);
        end
        step(); rv_b = 4'b1000;
        expect_grant(1, 3, 1'b1, 13'h030, 32'hBBBB_0003, 32'h0, 1'b0);
        step(); rv_b = '0;
        repeat (4) step();

        // Read-after-write to 0x010 with RD_LAT=3.
        set_req(0, 1'b1, 13'h010, 32'h0000_1234);
        rv_b = 4'b0001;
        expect_grant(1, 0, 1'b1, 13'h010, 32'h0000_1234, 32'h0, 1'b0);
        step(); set_req(1, 1'b0, 13'h010, 32'h0); rv_b = 4'b0010;
        expect_grant(1, 1, 1'b0, 13'h010, 32'h0, 32'h0000_1234, 1'b1);
        step(); rv_b = '0;
        repeat (10) step();

        final_chk = 1'b1;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
